// File: rtl/row_line_parser.sv
// row_line_parser: ASCII '@'/'.' byte stream to MSB-first bit rows with length, index and end marker.
module row_line_parser #(
  parameter int MAX_N = 8,
  parameter int MAX_N_W = (MAX_N <= 1) ? 1 : $clog2(MAX_N + 1),
  parameter int IDX_W = 16,
  parameter logic [7:0] ONE_CHAR = 8'h40,
  parameter logic [7:0] ZERO_CHAR = 8'h2E
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MAX_N-1:0]   out_row,
  output logic [MAX_N_W-1:0] out_n,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               err_overflow,
  output logic               err_char
);
  localparam logic [MAX_N-1:0] TOP = MAX_N'(1) << (MAX_N - 1);
  logic [MAX_N-1:0] acc_row, row_w;
  logic [MAX_N_W-1:0] acc_n, n_w;
  logic [IDX_W-1:0] idx_q;
  logic take, is_lf, is_bit, is_one, bad, full, emit;
  assign in_ready = !out_valid || out_ready;
  assign take = in_valid && in_ready;
  assign is_lf = in_data == 8'h0A;
  assign is_bit = !is_lf && in_data != 8'h0D;
  assign is_one = is_bit && in_data == ONE_CHAR;
  assign bad = is_bit && in_data != ONE_CHAR && in_data != ZERO_CHAR;
  assign full = acc_n == MAX_N_W'(MAX_N);
  // a saturated counter shifts the marker out entirely, so overflow bits vanish
  assign row_w = is_one ? acc_row | (TOP >> acc_n) : acc_row;
  assign n_w = acc_n + MAX_N_W'(is_bit && !full);
  assign emit = take && (is_lf || in_last);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_row <= '0;
      acc_n <= '0;
      idx_q <= '0;
      out_valid <= 1'b0;
      out_row <= '0;
      out_n <= '0;
      out_idx <= '0;
      out_last <= 1'b0;
      err_overflow <= 1'b0;
      err_char <= 1'b0;
    end else begin
      if (take) begin
        acc_row <= emit ? '0 : row_w;
        acc_n <= emit ? '0 : n_w;
        err_overflow <= err_overflow | (is_bit && full);
        err_char <= err_char | bad;
      end
      if (emit) begin
        out_row <= row_w;
        out_n <= n_w;
        out_idx <= idx_q;
        out_last <= in_last;
        idx_q <= idx_q + IDX_W'(1);
      end
      out_valid <= emit || (out_valid && !out_ready);
    end
  end
endmodule

// File: tb/tb_row_line_parser.sv
// tb_row_line_parser: directed plan scenarios plus random byte traffic against a line-level reference model.
module tb_row_line_parser;
  localparam int MAX_N = 8;
  typedef struct {
    logic [7:0] row;
    logic [3:0] n;
    logic [15:0] idx;
    logic last;
  } row_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic out_valid, out_ready = 1'b0, out_last, err_overflow, err_char;
  logic [7:0] out_row;
  logic [3:0] out_n;
  logic [15:0] out_idx;
  int checks = 0, errors = 0;
  row_t exp_q[$];
  row_t got[$];
  bit cols[$];
  int m_idx = 0;
  bit m_ovf = 0, m_chr = 0, took = 0;

  row_line_parser #(.MAX_N(MAX_N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_n(out_n), .out_idx(out_idx), .out_last(out_last), .err_overflow(err_overflow),
    .err_char(err_char)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_emit(input bit last);
    row_t r;
    r.row = '0;
    foreach (cols[i]) if (cols[i]) r.row[MAX_N-1-i] = 1'b1;
    r.n = 4'(cols.size());
    r.idx = 16'(m_idx);
    r.last = last;
    exp_q.push_back(r);
    m_idx++;
    cols.delete();
  endtask

  task automatic model_feed(input logic [7:0] b, input bit last);
    if (b != 8'h0A && b != 8'h0D) begin
      if (b != 8'h40 && b != 8'h2E) m_chr = 1;
      if (cols.size() < MAX_N) cols.push_back(b == 8'h40);
      else m_ovf = 1;
    end
    if (b == 8'h0A || last) model_emit(last);
  endtask

  task automatic cycle(input bit v, input logic [7:0] d, input bit l, input bit r);
    row_t a, e;
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    #1;
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(exp_q.size() == 0 || r));
    chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
    chk("err_char", 32'(err_char), 32'(m_chr));
    if (out_valid && out_ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.row = out_row; a.n = out_n; a.idx = out_idx; a.last = out_last;
      chk("row", 32'(a.row), 32'(e.row));
      chk("n", 32'(a.n), 32'(e.n));
      chk("idx", 32'(a.idx), 32'(e.idx));
      chk("last", 32'(a.last), 32'(e.last));
      got.push_back(a);
    end
    took = v && in_ready;
    if (took) model_feed(d, l);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit l, input bit r);
    int k = 0;
    do begin
      cycle(1, d, l, r);
      k++;
    end while (!took && k < 100);
    if (!took) chk("accept_timeout", 0, 1);
  endtask

  task automatic send(input string s, input bit last_end, input bit r);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], last_end && i == s.len() - 1, r);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(0, 8'h00, 0, 1);
  endtask

  task automatic chk_rst_zero();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_row", 32'(out_row), 0);
    chk("rst_out_n", 32'(out_n), 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_err_overflow", 32'(err_overflow), 0);
    chk("rst_err_char", 32'(err_char), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h40; in_last = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_rst_zero();
    exp_q.delete(); cols.delete(); m_idx = 0; m_ovf = 0; m_chr = 0;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk_rst_zero();
    rst_n = 1'b1;
  endtask

  task automatic chk_row(input string tag, input int k, input logic [7:0] row, input logic [3:0] n,
                         input logic [15:0] idx, input bit last);
    row_t a;
    a.row = 8'hxx; a.n = 4'hx; a.idx = 16'hxxxx; a.last = 1'bx;
    if (got.size() >= k) a = got[got.size() - k];
    chk({tag, "_row"}, 32'(a.row), 32'(row));
    chk({tag, "_n"}, 32'(a.n), 32'(n));
    chk({tag, "_idx"}, 32'(a.idx), 32'(idx));
    chk({tag, "_last"}, 32'(a.last), 32'(last));
  endtask

  initial begin
    int base;
    logic [7:0] d;
    int p;
    do_reset();
    send("@.@\n", 0, 1);
    idle(2);
    chk_row("basic", 1, 8'b1010_0000, 3, 0, 0);

    do_reset();
    send("@@\n", 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 8'h2E, 0, 0);
    chk("bp_held_row", 32'(out_row), 32'hC0);
    chk("bp_held_n", 32'(out_n), 2);
    send(".@\n", 0, 1);
    idle(2);
    chk_row("bp_first", 2, 8'b1100_0000, 2, 0, 0);
    chk_row("bp_second", 1, 8'b0100_0000, 2, 1, 0);

    do_reset();
    send("@@@@@@@@@@\n", 0, 1);
    idle(1);
    chk_row("ovf", 1, 8'hFF, 8, 0, 0);
    send(".@\n", 0, 1);
    idle(2);
    chk("ovf_sticky", 32'(err_overflow), 1);

    do_reset();
    send("@\r\n\nx@\n", 0, 1);
    idle(2);
    chk_row("crlf", 3, 8'h80, 1, 0, 0);
    chk_row("blank", 2, 8'h00, 0, 1, 0);
    chk_row("badchar", 1, 8'b0100_0000, 2, 2, 0);
    chk("err_char_set", 32'(err_char), 1);

    do_reset();
    base = got.size();
    send(".@", 1, 1);
    idle(2);
    chk_row("last_data", 1, 8'b0100_0000, 2, 0, 1);
    send("\n", 1, 1);
    idle(2);
    chk("last_lf_count", 32'(got.size() - base), 2);
    chk_row("last_lf", 1, 8'h00, 0, 1, 1);

    do_reset();
    send("@\nx@@", 0, 1);
    idle(1);
    do_reset();
    send(".\n", 0, 1);
    idle(2);
    chk_row("after_rst", 1, 8'h00, 1, 0, 0);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      p = $urandom_range(99);
      d = p < 35 ? 8'h40 : p < 70 ? 8'h2E : p < 85 ? 8'h0A : p < 90 ? 8'h0D : 8'($urandom_range(255));
      cycle($urandom_range(9) < 7, d, $urandom_range(99) < 3, $urandom_range(9) < 7);
    end
    idle(3);
    chk("rand_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
